// File: rtl/xidoo_pkg.sv
// rtl/xidoo_pkg.sv - shared types and default widths for the xidoo memory arbiter
package xidoo_pkg;

    localparam int XIDOO_AW = 5;
    localparam int XIDOO_DW = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CMD   = 2'd1,
        ARB_RDATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/xidoo_arb_pick.sv
// rtl/xidoo_arb_pick.sv - winner select; round-robin when XIDOO_ARB_RR_EN is defined, else fixed CPU priority
module xidoo_arb_pick
    import xidoo_pkg::*;
(
    input  logic       cpu_req,
    input  logic       ldr_req,
    input  arb_owner_t last_owner,
    output arb_owner_t winner
);

`ifdef XIDOO_ARB_RR_EN
    // On a collision the port that did not win last time goes first
    always_comb begin
        winner = OWN_CPU;
        if (cpu_req && ldr_req) begin
            winner = (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
        end else if (!cpu_req && ldr_req) begin
            winner = OWN_LDR;
        end
    end
`else
    // History is irrelevant under fixed priority
    logic unused_last_owner;
    assign unused_last_owner = (last_owner == OWN_LDR);

    // CPU always wins; the loader only gets in when the CPU is quiet
    always_comb begin
        winner = OWN_CPU;
        if (!cpu_req && ldr_req) begin
            winner = OWN_LDR;
        end
    end
`endif

endmodule

// File: rtl/xidoo_mem_arbiter.sv
// rtl/xidoo_mem_arbiter.sv - CPU/loader arbiter and sequencer for the single-port memory (option: XIDOO_ARB_RR_EN)
module xidoo_mem_arbiter
    import xidoo_pkg::*;
#(
    parameter int AW = XIDOO_AW,
    parameter int DW = XIDOO_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_t    state;
    arb_state_t    state_next;
    logic          capture;
    logic          rd_done;
    arb_owner_t    winner;
    arb_owner_t    owner_q;
    arb_owner_t    last_owner;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    xidoo_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .ldr_req    (ldr_req),
        .last_owner (last_owner),
        .winner     (winner)
    );

    // Fields of whichever port wins this cycle
    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == OWN_LDR) begin
            sel_we    = ldr_we;
            sel_addr  = ldr_addr;
            sel_wdata = ldr_wdata;
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the capture / read-completion strobes
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        rd_done    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (cpu_req || ldr_req) begin
                    capture    = 1'b1;
                    state_next = ARB_CMD;
                end
            end
            ARB_CMD: begin
                state_next = we_q ? ARB_IDLE : ARB_RDATA;
            end
            ARB_RDATA: begin
                rd_done    = 1'b1;
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Transaction fields, grant/valid pulses and per-port read data; every port-side output is a flop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q    <= OWN_CPU;
            last_owner <= OWN_LDR;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_gnt    <= 1'b0;
            ldr_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            cpu_gnt    <= capture && (winner == OWN_CPU);
            ldr_gnt    <= capture && (winner == OWN_LDR);
            cpu_rvalid <= rd_done && (owner_q == OWN_CPU);
            ldr_rvalid <= rd_done && (owner_q == OWN_LDR);
            busy       <= (state_next != ARB_IDLE);
            if (capture) begin
                owner_q    <= winner;
                last_owner <= winner;
                we_q       <= sel_we;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
            end
            if (rd_done && (owner_q == OWN_CPU)) begin
                cpu_rdata <= mem_rdata;
            end
            if (rd_done && (owner_q == OWN_LDR)) begin
                ldr_rdata <= mem_rdata;
            end
        end
    end

    // Fields are only loaded on entry to ARB_CMD, so outside it they hold the last command
    assign mem_en    = (state == ARB_CMD);
    assign mem_we    = (state == ARB_CMD) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_xidoo_mem_arbiter.sv
// tb/tb_xidoo_mem_arbiter.sv - scoreboard bench for xidoo_mem_arbiter
module tb_xidoo_mem_arbiter;

    typedef struct {
        int         cyc;
        int         port;
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clock, reset;
    logic       cpu_req, cpu_we, ldr_req, ldr_we;
    logic [4:0] cpu_addr, ldr_addr, mem_addr;
    logic [7:0] cpu_wdata, ldr_wdata, mem_wdata, mem_rdata;
    logic [7:0] cpu_rdata, ldr_rdata;
    logic       cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
    logic       mem_en, mem_we, busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];
    ev_t        gq[$];
    ev_t        rq[$];
    int         bq[$];
    int         free_at = 0;
    int         last = 1;
    logic [7:0] held [2];
    int         gcnt [2];
    int         gcyc [2];

    xidoo_mem_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] init_val(input int i);
        return (i == 31) ? 8'h3C : 8'(i * 37 + 11);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read memory attached to the DUT
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
            mem_rdata <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model: transaction-level occupancy and arbitration rules
    always @(negedge clock) begin
        int         p;
        logic       w;
        logic [4:0] a;
        logic [7:0] d;
        if (reset) begin
            gq.delete();
            rq.delete();
            bq.delete();
            free_at = 0;
            last = 1;
            for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        end else if (cyc >= free_at && (cpu_req || ldr_req)) begin
`ifdef XIDOO_ARB_RR_EN
            if (cpu_req && ldr_req) p = 1 - last;
            else p = cpu_req ? 0 : 1;
`else
            p = cpu_req ? 0 : 1;
`endif
            w = (p == 0) ? cpu_we : ldr_we;
            a = (p == 0) ? cpu_addr : ldr_addr;
            d = (p == 0) ? cpu_wdata : ldr_wdata;
            gq.push_back('{cyc + 1, p, w, a, d});
            bq.push_back(cyc + 1);
            if (w) begin
                ref_mem[a] = d;
                free_at = cyc + 2;
            end else begin
                rq.push_back('{cyc + 3, p, 1'b0, a, ref_mem[a]});
                bq.push_back(cyc + 2);
                free_at = cyc + 3;
            end
            last = p;
        end
    end

    // Monitor: compares DUT outputs against the expected event queues every cycle
    always @(negedge clock) begin
        ev_t  e;
        logic eb;
        if (reset) begin
            held[0] = 8'h00;
            held[1] = 8'h00;
            chk("reset_outputs",
                64'({cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_en, mem_we, busy,
                     cpu_rdata, ldr_rdata, mem_addr, mem_wdata}), 64'd0);
        end else begin
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                chk("gnt_missed", 64'(gq[0].cyc), 64'(cyc));
                void'(gq.pop_front());
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("rvalid_missed", 64'(rq[0].cyc), 64'(cyc));
                void'(rq.pop_front());
            end
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                e = gq.pop_front();
                chk("gnt_cmd",
                    64'({cpu_gnt, ldr_gnt, mem_en, mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)}),
                    64'({e.port == 0, e.port == 1, 1'b1, e.we, e.addr, (e.we ? e.data : 8'h00)}));
            end else begin
                chk("idle_cmd", 64'({cpu_gnt, ldr_gnt, mem_en, mem_we}), 64'd0);
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                e = rq.pop_front();
                held[e.port] = e.data;
                chk("rvalid", 64'({cpu_rvalid, ldr_rvalid}), 64'({e.port == 0, e.port == 1}));
            end else begin
                chk("rvalid_idle", 64'({cpu_rvalid, ldr_rvalid}), 64'd0);
            end
            chk("rdata_held", 64'({cpu_rdata, ldr_rdata}), 64'({held[0], held[1]}));
            eb = (bq.size() > 0 && bq[0] == cyc);
            if (eb) void'(bq.pop_front());
            chk("busy", 64'(busy), 64'(eb));
        end
    end

    // Grant bookkeeping for the directed collision and hold-off checks
    always @(negedge clock) begin
        if (cpu_gnt) begin gcnt[0] = gcnt[0] + 1; gcyc[0] = cyc; end
        if (ldr_gnt) begin gcnt[1] = gcnt[1] + 1; gcyc[1] = cyc; end
    end

    // One request/grant handshake; call just after a rising edge
    task automatic txn(input int p, input logic w, input logic [4:0] a, input logic [7:0] d);
        int   n;
        logic seen;
        if (p == 0) begin
            cpu_we = w; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        end else begin
            ldr_we = w; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clock);
            seen = (p == 0) ? cpu_gnt : ldr_gnt;
            n++;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL gnt_timeout port %0d: got no grant in 200 cycles, required a grant", p);
        end
        @(posedge clock);
        #1;
        if (p == 0) cpu_req = 1'b0;
        else        ldr_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        gcnt[0] = 0; gcnt[1] = 0; gcyc[0] = 0; gcyc[1] = 0;
        held[0] = 8'h00; held[1] = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;

        // CPU write 03 <- A5; FSM idle again in cycle 2
        txn(0, 1'b1, 5'h03, 8'hA5);
        chk("write_idle_c2", 64'({busy, mem_en}), 64'd0);

        // LDR read of 1F returns 3C in cycle 3, CPU data untouched
        txn(1, 1'b0, 5'h1F, 8'h00);
        @(posedge clock);
        @(negedge clock);
        chk("ldr_read_c3", 64'({ldr_rvalid, ldr_rdata, cpu_rdata}), 64'({1'b1, 8'h3C, 8'h00}));
        @(posedge clock);
        #1;

        // Collision: both hold writes for four grant slots
        gcnt[0] = 0; gcnt[1] = 0;
        cpu_we = 1'b1; cpu_addr = 5'h04; cpu_wdata = 8'h11; cpu_req = 1'b1;
        ldr_we = 1'b1; ldr_addr = 5'h05; ldr_wdata = 8'h22; ldr_req = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;
`ifdef XIDOO_ARB_RR_EN
        chk("collision_counts", 64'({gcnt[0][7:0], gcnt[1][7:0]}), 64'({8'd2, 8'd2}));
`else
        chk("collision_counts", 64'({gcnt[0][7:0], gcnt[1][7:0]}), 64'({8'd4, 8'd0}));
`endif

        // LDR raised during a CPU read's command cycle waits until the read is done
        fork
            txn(0, 1'b0, 5'h04, 8'h00);
            begin
                @(posedge clock);
                #1;
                txn(1, 1'b1, 5'h06, 8'h5A);
            end
        join
        chk("held_off_gap", 64'(gcyc[1] - gcyc[0]), 64'd3);
        @(posedge clock);
        #1;

        // Reset in ARB_RDATA drops the read
        cpu_we = 1'b0; cpu_addr = 5'h1F; cpu_req = 1'b1;
        @(posedge clock);
        #1 cpu_req = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("reset_mid_read",
            64'({mem_en, busy, cpu_rvalid, cpu_rdata, ldr_rdata}), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        txn(0, 1'b0, 5'h1F, 8'h00);
        repeat (3) @(posedge clock);
        #1;
        chk("read_after_reset", 64'(cpu_rdata), 64'(8'h3C));

        // Randomized concurrent traffic from both ports
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(1, 4)) @(posedge clock);
                    #1;
                    txn(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(1, 4)) @(posedge clock);
                    #1;
                    txn(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
                end
            end
        join

        repeat (6) @(posedge clock);
        #1;
        chk("queues_drained", 64'(gq.size() + rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
